// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state encoding, access-size
// codes and the alignment rule used to reject unaligned requests.
package lsu_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Access size codes (2'b11 is reserved and behaves as a word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Halves need an even address, words (and the reserved code) need A[1:0]==0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the load/store unit. Store side builds byte enables
// and lane-replicated write data; load side shifts the selected lanes down and
// sign- or zero-extends them. Purely combinational.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Store lanes: replicate the right-justified data across every lane so the
    // byte enables alone pick the bytes memory writes
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load extraction: move the addressed lane to bit 0, then extend
    always_comb begin
        ld_shifted = ld_rdata >> {ld_offset, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Accepts one access at a time from the pipeline,
// runs a req/ack handshake with data memory (with a bus-error timeout),
// aligns store lanes, extends load data and stalls the pipeline meanwhile.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       Write_Data,
    output logic [31:0]       Read_Data,
    output logic              Stall,
    output logic              Misaligned,
    output logic              Bus_Error,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [ADDR_W-3:0] Mem_Addr,
    output logic [3:0]        Mem_Be,
    output logic [31:0]       Mem_Wdata,
    input  logic              Mem_Ack,
    input  logic [31:0]       Mem_Rdata
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_reg, state_next;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [ADDR_W-3:0] addr_reg;
    logic              we_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic [1:0]        size_reg;
    logic [1:0]        offset_reg;
    logic              signed_reg;
    logic [31:0]       read_data_reg;

    logic        in_idle, in_req;
    logic        req_in, mis_in, accept;
    logic        ack_hit, timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign in_idle     = (state_reg == ST_IDLE);
    assign in_req      = (state_reg == ST_REQ);
    assign req_in      = MemRead | MemWrite;
    assign mis_in      = is_misaligned(Size, Address[1:0]);
    assign accept      = in_idle & req_in & ~mis_in;
    assign ack_hit     = in_req & Mem_Ack;
    // Last allowed REQ cycle without an ack; an ack in that same cycle still wins
    assign timeout_hit = in_req & ~Mem_Ack & (to_cnt_reg == TO_W'(TIMEOUT - 1));

    lsu_byte_lane u_byte_lane (
        .st_size   (Size),
        .st_offset (Address[1:0]),
        .st_data   (Write_Data),
        .st_be     (lane_be),
        .st_wdata  (lane_wdata),
        .ld_size   (size_reg),
        .ld_offset (offset_reg),
        .ld_signed (signed_reg),
        .ld_rdata  (Mem_Rdata),
        .ld_data   (load_data)
    );

    // Next-state logic for the IDLE -> REQ -> DONE -> IDLE sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ:  if (ack_hit || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and REQ-cycle timeout counter (cleared on entering REQ)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            to_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept)
                to_cnt_reg <= '0;
            else if (in_req)
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    // Capture the access when accepted so memory sees stable request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            be_reg     <= '0;
            wdata_reg  <= '0;
            size_reg   <= SZ_BYTE;
            offset_reg <= '0;
            signed_reg <= 1'b0;
        end else if (accept) begin
            addr_reg   <= Address[ADDR_W-1:2];
            we_reg     <= MemWrite;
            be_reg     <= lane_be;
            wdata_reg  <= lane_wdata;
            size_reg   <= Size;
            offset_reg <= Address[1:0];
            signed_reg <= ~Unsigned;
        end
    end

    // Load result: updated on ack, zeroed on a timed-out load, else held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            read_data_reg <= '0;
        else if (ack_hit && !we_reg)
            read_data_reg <= load_data;
        else if (timeout_hit && !we_reg)
            read_data_reg <= '0;
    end

    // Combinational pulses are forced low while reset is asserted so the
    // pipeline sees no stall even if it still presents a request
    assign Stall      = rst_n & (accept | in_req);
    assign Misaligned = rst_n & in_idle & req_in & mis_in;
    assign Bus_Error  = timeout_hit;
    assign Mem_Req    = in_req;
    assign Mem_We     = we_reg;
    assign Mem_Addr   = addr_reg;
    assign Mem_Be     = be_reg;
    assign Mem_Wdata  = wdata_reg;
    assign Read_Data  = read_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a behavioural model of memory-side fields and the
// load result.
module tb_load_store_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [1:0]        Size = 2'b00;
    logic              Unsigned = 1'b0;
    logic [ADDR_W-1:0] Address = '0;
    logic [31:0]       Write_Data = '0;
    logic [31:0]       Read_Data;
    logic              Stall;
    logic              Misaligned;
    logic              Bus_Error;
    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-3:0] Mem_Addr;
    logic [3:0]        Mem_Be;
    logic [31:0]       Mem_Wdata;
    logic              Mem_Ack = 1'b0;
    logic [31:0]       Mem_Rdata = '0;

    int n_cmp = 0;
    int n_mis = 0;
    int n_txn = 0;
    logic [31:0] rd_model = '0;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Size       (Size),
        .Unsigned   (Unsigned),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .Stall      (Stall),
        .Misaligned (Misaligned),
        .Bus_Error  (Bus_Error),
        .Mem_Req    (Mem_Req),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_Be     (Mem_Be),
        .Mem_Wdata  (Mem_Wdata),
        .Mem_Ack    (Mem_Ack),
        .Mem_Rdata  (Mem_Rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---- behavioural reference ----
    function automatic int eff_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % eff_bytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int n = eff_bytes(sz);
        int o = int'(a % 4);
        return 4'(((1 << n) - 1) << o);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (eff_bytes(sz))
            1:       return (d % 256) * 32'h01010101;
            2:       return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] w;
        logic [31:0] v;
        w = rdata >> (8 * (a % 4));
        case (eff_bytes(sz))
            1: begin
                v = w % 256;
                if (!uns && v >= 128) v = v + 32'hFFFFFF00;
            end
            2: begin
                v = w % 65536;
                if (!uns && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // One complete access from IDLE back to IDLE. ack_at = REQ cycle in which
    // memory acks (1-based); 0 = memory never acks.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input int ack_at);
        bit is_store;
        bit acked;
        int stalls;
        int req_cycles;
        is_store = wr;
        acked    = 1'b0;
        stalls   = 0;
        req_cycles = 0;
        n_txn++;
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
        Address = addr; Write_Data = data;
        @(negedge clk);
        if (ref_misaligned(sz, addr)) begin
            check({name, ".mis_pulse"}, 32'(Misaligned), 32'd1);
            check({name, ".mis_stall"}, 32'(Stall), 32'd0);
            check({name, ".mis_req"}, 32'(Mem_Req), 32'd0);
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0;
            @(negedge clk);
            check({name, ".mis_idle_req"}, 32'(Mem_Req), 32'd0);
            check({name, ".mis_rd_hold"}, Read_Data, rd_model);
            $display("txn %0d %s: misaligned A=0x%08h size=%0d rejected", n_txn, name, addr, sz);
            @(posedge clk); #1;
            return;
        end
        check({name, ".acc_stall"}, 32'(Stall), 32'd1);
        check({name, ".acc_mis"}, 32'(Misaligned), 32'd0);
        if (Stall) stalls++;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk); #1;
            Mem_Ack   = (k == ack_at);
            Mem_Rdata = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            req_cycles++;
            if (Stall) stalls++;
            check({name, ".req"}, 32'(Mem_Req), 32'd1);
            check({name, ".we"}, 32'(Mem_We), 32'(is_store));
            check({name, ".addr"}, 32'(Mem_Addr), addr >> 2);
            check({name, ".be"}, 32'(Mem_Be), 32'(ref_be(sz, addr)));
            check({name, ".wdata"}, Mem_Wdata, ref_wdata(sz, data));
            if (k == ack_at) begin
                acked = 1'b1;
                check({name, ".no_buserr"}, 32'(Bus_Error), 32'd0);
                break;
            end
            check({name, ".buserr"}, 32'(Bus_Error), (k == TIMEOUT) ? 32'd1 : 32'd0);
        end
        if (!is_store) rd_model = acked ? ref_load(sz, uns, addr, rdata) : 32'd0;
        // DONE: memory glitches an ack here, which must be ignored
        @(posedge clk); #1;
        Mem_Ack = 1'b1; Mem_Rdata = $urandom;
        @(negedge clk);
        check({name, ".done_stall"}, 32'(Stall), 32'd0);
        check({name, ".done_req"}, 32'(Mem_Req), 32'd0);
        check({name, ".done_buserr"}, 32'(Bus_Error), 32'd0);
        check({name, ".rdata"}, Read_Data, rd_model);
        check({name, ".stall_cycles"}, 32'(stalls), 32'(1 + req_cycles));
        @(posedge clk); #1;
        Mem_Ack = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check({name, ".idle_req"}, 32'(Mem_Req), 32'd0);
        check({name, ".idle_rd"}, Read_Data, rd_model);
        $display("txn %0d %s: %s A=0x%08h size=%0d uns=%0d ack@%0d stall=%0d rd=0x%08h",
                 n_txn, name, is_store ? "store" : "load", addr, sz, uns, ack_at, stalls, Read_Data);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0]  r_sz;
        logic [31:0] r_addr;
        int          r_op;
        int          r_ack;

        // Reset state
        #12;
        check("rst.read_data", Read_Data, 32'd0);
        check("rst.stall", 32'(Stall), 32'd0);
        check("rst.mem_req", 32'(Mem_Req), 32'd0);
        check("rst.mem_be", 32'(Mem_Be), 32'd0);
        check("rst.bus_error", 32'(Bus_Error), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: LW with ack in third REQ cycle -> 4 stall cycles
        run_access("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        check("lw.const", Read_Data, 32'hDEADBEEF);
        // 2: byte/half extension
        run_access("lb", 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF1234, 1);
        check("lb.const", Read_Data, 32'hFFFFFF80);
        run_access("lbu", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF1234, 2);
        check("lbu.const", Read_Data, 32'h00000080);
        run_access("lhu", 1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80FF1234, 1);
        check("lhu.const", Read_Data, 32'h000080FF);
        // 3: stores leave Read_Data unchanged
        run_access("sb", 0, 1, 2'b00, 0, 32'h201, 32'hAB, 32'h0, 2);
        run_access("sh", 0, 1, 2'b01, 0, 32'h202, 32'h1234CDEF, 32'h0, 1);
        check("store.rd_hold", Read_Data, 32'h000080FF);
        // 4: misaligned word load
        run_access("lw_mis", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 1);
        check("mis.rd_hold", Read_Data, 32'h000080FF);
        // 5: no ack -> bus error after TIMEOUT REQ cycles
        run_access("lw_to", 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h12345678, 0);
        check("to.const", Read_Data, 32'h0);
        // ack on the last allowed cycle still completes normally
        run_access("lw_edge", 1, 0, 2'b10, 0, 32'h304, 32'h0, 32'hCAFEF00D, TIMEOUT);

        // 6: reset while in REQ
        MemRead = 1'b1; Size = 2'b10; Unsigned = 1'b0; Address = 32'h40;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq.req_before", 32'(Mem_Req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstreq.req_drop", 32'(Mem_Req), 32'd0);
        check("rstreq.stall_drop", 32'(Stall), 32'd0);
        check("rstreq.read_data", Read_Data, 32'd0);
        rd_model = 32'd0;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_access("lw_after_rst", 1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0BADF00D, 2);

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            r_op   = int'($urandom_range(0, 2));
            r_sz   = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                // bias toward aligned addresses for more completed accesses
                r_addr = r_addr & ~((32'(eff_bytes(r_sz))) - 32'd1);
            end
            r_ack = int'($urandom_range(1, 5));
            if ($urandom_range(0, 19) == 0) r_ack = 0;
            if ($urandom_range(0, 19) == 0) r_ack = TIMEOUT;
            run_access("rnd", (r_op != 1), (r_op != 0), r_sz, 1'($urandom_range(0, 1)),
                       r_addr, $urandom, $urandom, r_ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #2000000;
        n_mis++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog");
    end

endmodule
